ipv4_tx_multi_arbiter: RTL and testbench
========================================

Name: ipv4_tx_multi_arbiter

Overview:
Parametrised N-port successor to the fixed three-source L3 transmit arbiter in the TCP/IP stack. Each source gets a per-port frame buffer with commit/drop semantics. A grant FSM drains whole frames one at a time onto a single downstream L3 transmit stream and honours the downstream busy signal. Fixed-priority or round-robin selection is chosen by parameter. Overflowing frames are dropped cleanly.

Parameters:
NUM_PORTS, 4, number of source streams (2..16)
DATA_WIDTH, 32, data word width in bits (multiple of 8)
DEPTH_WORDS, 512, per-port data buffer depth in words (power of 2)
MAX_FRAMES, 8, per-port committed-frame length FIFO depth (power of 2)
ROUND_ROBIN, 1, 1 = round-robin, 0 = fixed priority with lowest index first

Ports:
clk  in  1  core clock; all logic is in this domain
rst  in  1  synchronous active-high reset
in_start  in  NUM_PORTS  per-port start-of-frame pulse
in_data_valid  in  NUM_PORTS  per-port word strobe
in_data  in  NUM_PORTS*DATA_WIDTH  per-port data; port p is at [p*DATA_WIDTH +: DATA_WIDTH]
in_bytes_valid  in  NUM_PORTS*BV  per-port valid byte count, where BV = $clog2(DATA_WIDTH/8)+1
in_commit  in  NUM_PORTS  per-port end-of-frame, frame good
in_drop  in  NUM_PORTS  per-port abort of the current frame
out_start  out  1  downstream start pulse
out_data_valid  out  1  downstream word strobe
out_data  out  DATA_WIDTH  downstream data
out_bytes_valid  out  BV  downstream byte count
out_commit  out  1  downstream end-of-frame pulse
tx_busy  in  1  downstream busy; no new grant is issued while high
overflow_drop  out  NUM_PORTS  one-cycle pulse when a frame on port p is discarded for lack of space
grant_port  out  $clog2(NUM_PORTS)  index of the port currently or last granted

Behaviour:
- Reset: all pointers, counts, FSM and round-robin pointer clear. All outputs read 0, grant_port reads 0. A partially written or partially sent frame is discarded; no out_commit is issued for it.
- Write side, per port, independent of the other ports:
  - in_start sets the tentative write pointer to the committed write pointer and clears the bad flag.
  - Each in_data_valid writes {bytes_valid, data} at the tentative pointer, then increments it.
  - If the buffer is full (tentative - read pointer == DEPTH_WORDS), the word is not written and the bad flag is set.
  - in_commit with the bad flag clear and the length FIFO not full: push the word count (tentative - committed) to the length FIFO, then committed = tentative.
  - in_commit with the bad flag set or the length FIFO full: roll back the tentative pointer and pulse overflow_drop[p] on the next cycle.
  - in_drop rolls back silently.
  - A zero-length commit is discarded silently.
  - Write and read on the same port in the same cycle are legal.
- Pointers are one bit wider than the address to distinguish full from empty; they wrap modulo 2*DEPTH_WORDS.
- A port is eligible when its length FIFO is non-empty.
- FSM states: IDLE, START, DATA, COMMIT.
  - IDLE: if tx_busy is low and any port is eligible at cycle T, select a winner and register grant_port. Round-robin searches from last grant + 1, wrapping. Priority mode takes the lowest index. Pop that port's length into a word counter. Go to START.
  - START: out_start = 1 at T+1; issue the first RAM read. Go to DATA.
  - DATA: the buffer has 1-cycle read latency. out_data_valid = 1 with consecutive words from T+2 through T+1+len; no gaps and no backpressure. The read pointer advances once per word. Go to COMMIT after the last word.
  - COMMIT: out_commit = 1 for one cycle, at T+2+len. Go to IDLE.
- Earliest next out_start is T+4+len (back-to-back grants need one IDLE cycle).
- tx_busy is sampled only in IDLE. Asserting it mid-frame does not stall the frame.
- Outputs are registered. out_data and out_bytes_valid hold the last word when idle.

Test Plan:
- Single frame, NUM_PORTS=4: port 2 writes 5 words 0x11..0x55, bytes_valid 4,4,4,4,2, then commits → out_start, then 5 consecutive words with last bytes_valid=2, then out_commit on the next cycle; grant_port=2; no overflow_drop.
- Round-robin: ports 0, 1 and 3 each commit 2 frames of 3 words before the drain starts → grant order 0,1,3,0,1,3.
- Priority mode (ROUND_ROBIN=0): same stimulus → grant order 0,0,1,1,3,3.
- Overflow: DEPTH_WORDS=16; port 1 writes 20 words then commits → overflow_drop[1] pulses once; nothing is sent. A following 4-word frame on port 1 is sent intact.
- Drop and tx_busy: port 0 writes 3 words then asserts in_drop, then commits a 2-word frame while tx_busy=1 for 10 cycles → no out_start until the cycle after tx_busy falls; only the 2-word frame appears.
- Reset mid-frame: assert rst during DATA of an 8-word frame → outputs read 0 the next cycle; no out_commit; buffers are empty after reset; a new frame is then sent normally.

Source files
------------

// File: rtl/ipv4_tx_multi_arbiter.sv
// rtl/ipv4_tx_multi_arbiter.sv - N-port whole-frame L3 transmit arbiter with per-port commit/drop buffers
module ipv4_tx_multi_arbiter #(
  parameter int NUM_PORTS   = 4,
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH_WORDS = 512,
  parameter int MAX_FRAMES  = 8,
  parameter int ROUND_ROBIN = 1,
  localparam int BV = $clog2(DATA_WIDTH/8) + 1,
  localparam int GW = $clog2(NUM_PORTS)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_PORTS-1:0]          in_start,
  input  logic [NUM_PORTS-1:0]          in_data_valid,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] in_data,
  input  logic [NUM_PORTS*BV-1:0]       in_bytes_valid,
  input  logic [NUM_PORTS-1:0]          in_commit,
  input  logic [NUM_PORTS-1:0]          in_drop,
  output logic                          out_start,
  output logic                          out_data_valid,
  output logic [DATA_WIDTH-1:0]         out_data,
  output logic [BV-1:0]                 out_bytes_valid,
  output logic                          out_commit,
  input  logic                          tx_busy,
  output logic [NUM_PORTS-1:0]          overflow_drop,
  output logic [GW-1:0]                 grant_port
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int PW = AW + 1;
  localparam int FW = $clog2(MAX_FRAMES);
  localparam int WW = BV + DATA_WIDTH;

  typedef enum logic [1:0] {IDLE, START, DATA, COMMIT} state_t;

  state_t              state, state_next;
  logic                grant_fire, rd_en, commit_en;
  logic [NUM_PORTS-1:0] eligible;
  logic [NUM_PORTS-1:0] elig_rot;
  logic [PW-1:0]       head_len [NUM_PORTS];
  logic [WW-1:0]       rd_word  [NUM_PORTS];
  logic [GW-1:0]       rr_ptr, offset, winner;
  logic [GW:0]         sum;
  logic                found;
  logic [PW-1:0]       word_cnt;

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    logic [WW-1:0] mem [DEPTH_WORDS];
    logic [PW-1:0] len_fifo [MAX_FRAMES];
    logic [PW-1:0] wr_tent, wr_comm, rd_ptr;
    logic [FW:0]   lf_wr, lf_rd;
    logic          bad, ovf_q;
    logic [PW-1:0] tent_base, tent_next, frame_len;
    logic          bad_base, bad_next, full, do_write, lf_full;
    logic          commit_ok, commit_fail, pop, rd_adv;

    // start, data and commit may coincide; they are applied in that order
    always_comb begin
      tent_base   = in_start[p] ? wr_comm : wr_tent;
      bad_base    = in_start[p] ? 1'b0 : bad;
      full        = (tent_base - rd_ptr) == PW'(DEPTH_WORDS);
      do_write    = in_data_valid[p] && !full;
      bad_next    = bad_base || (in_data_valid[p] && full);
      tent_next   = tent_base + PW'(do_write);
      frame_len   = tent_next - wr_comm;
      lf_full     = (lf_wr - lf_rd) == (FW+1)'(MAX_FRAMES);
      commit_ok   = in_commit[p] && !bad_next && (frame_len != '0) && !lf_full;
      commit_fail = in_commit[p] && (bad_next || ((frame_len != '0) && lf_full));
    end

    assign pop    = grant_fire && (winner == GW'(p));
    assign rd_adv = rd_en && (grant_port == GW'(p));

    always_ff @(posedge clk) begin
      if (do_write)
        mem[tent_base[AW-1:0]] <= {in_bytes_valid[p*BV +: BV], in_data[p*DATA_WIDTH +: DATA_WIDTH]};
      if (commit_ok)
        len_fifo[lf_wr[FW-1:0]] <= frame_len;
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        wr_tent <= '0;
        wr_comm <= '0;
        rd_ptr  <= '0;
        lf_wr   <= '0;
        lf_rd   <= '0;
        bad     <= 1'b0;
        ovf_q   <= 1'b0;
      end else begin
        wr_tent <= tent_next;
        bad     <= bad_next;
        ovf_q   <= commit_fail;
        if (commit_ok) begin
          wr_comm <= tent_next;
          lf_wr   <= lf_wr + 1'b1;
          bad     <= 1'b0;
        end else if (in_commit[p] || in_drop[p]) begin
          wr_tent <= wr_comm;
          bad     <= 1'b0;
        end
        if (pop)
          lf_rd <= lf_rd + 1'b1;
        if (rd_adv)
          rd_ptr <= rd_ptr + 1'b1;
      end
    end

    assign eligible[p]      = lf_wr != lf_rd;
    assign head_len[p]      = len_fifo[lf_rd[FW-1:0]];
    assign rd_word[p]       = mem[rd_ptr[AW-1:0]];
    assign overflow_drop[p] = ovf_q;
  end

  // rotate so the search always starts at bit 0, then map the offset back
  always_comb begin
    elig_rot = NUM_PORTS'({eligible, eligible} >> rr_ptr);
    offset   = '0;
    found    = 1'b0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if (elig_rot[i]) begin
        found  = 1'b1;
        offset = GW'(i);
      end
    end
    sum    = {1'b0, rr_ptr} + {1'b0, offset};
    winner = GW'((sum >= (GW+1)'(NUM_PORTS)) ? sum - (GW+1)'(NUM_PORTS) : sum);
  end

  always_ff @(posedge clk) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    grant_fire = 1'b0;
    rd_en      = 1'b0;
    commit_en  = 1'b0;
    case (state)
      IDLE: begin
        if (!tx_busy && found) begin
          grant_fire = 1'b1;
          state_next = START;
        end
      end
      START: begin
        rd_en      = 1'b1;
        state_next = DATA;
      end
      DATA: begin
        if (word_cnt != '0) begin
          rd_en = 1'b1;
        end else begin
          commit_en  = 1'b1;
          state_next = COMMIT;
        end
      end
      COMMIT: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // memory read data lands straight in the output register (1-cycle latency)
  always_ff @(posedge clk) begin
    if (rst) begin
      grant_port      <= '0;
      rr_ptr          <= '0;
      word_cnt        <= '0;
      out_start       <= 1'b0;
      out_data_valid  <= 1'b0;
      out_commit      <= 1'b0;
      out_data        <= '0;
      out_bytes_valid <= '0;
    end else begin
      out_start      <= grant_fire;
      out_data_valid <= rd_en;
      out_commit     <= commit_en;
      if (grant_fire) begin
        grant_port <= winner;
        word_cnt   <= head_len[winner];
        if (ROUND_ROBIN != 0)
          rr_ptr <= (winner == GW'(NUM_PORTS - 1)) ? '0 : winner + 1'b1;
      end
      if (rd_en) begin
        {out_bytes_valid, out_data} <= rd_word[grant_port];
        word_cnt <= word_cnt - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ipv4_tx_multi_arbiter.sv
// tb/tb_ipv4_tx_multi_arbiter.sv - round-robin and priority instances checked against a frame-level model
module tb_ipv4_tx_multi_arbiter;
  localparam int NP    = 4;
  localparam int DW    = 32;
  localparam int DEPTH = 16;
  localparam int MAXF  = 4;
  localparam int BV    = 3;
  localparam int GW    = 2;

  typedef logic [BV+DW-1:0] word_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic [NP-1:0]     in_start, in_data_valid, in_commit, in_drop;
  logic [NP*DW-1:0]  in_data;
  logic [NP*BV-1:0]  in_bytes_valid;
  logic              tx_busy;

  logic              o_start [2];
  logic              o_dv    [2];
  logic              o_commit[2];
  logic [DW-1:0]     o_data  [2];
  logic [BV-1:0]     o_bv    [2];
  logic [NP-1:0]     o_ovf   [2];
  logic [GW-1:0]     o_gp    [2];

  ipv4_tx_multi_arbiter #(.NUM_PORTS(NP), .DATA_WIDTH(DW), .DEPTH_WORDS(DEPTH),
                          .MAX_FRAMES(MAXF), .ROUND_ROBIN(1)) u_rr (
    .clk(clk), .rst(rst), .in_start(in_start), .in_data_valid(in_data_valid),
    .in_data(in_data), .in_bytes_valid(in_bytes_valid), .in_commit(in_commit),
    .in_drop(in_drop), .out_start(o_start[0]), .out_data_valid(o_dv[0]),
    .out_data(o_data[0]), .out_bytes_valid(o_bv[0]), .out_commit(o_commit[0]),
    .tx_busy(tx_busy), .overflow_drop(o_ovf[0]), .grant_port(o_gp[0]));

  ipv4_tx_multi_arbiter #(.NUM_PORTS(NP), .DATA_WIDTH(DW), .DEPTH_WORDS(DEPTH),
                          .MAX_FRAMES(MAXF), .ROUND_ROBIN(0)) u_pr (
    .clk(clk), .rst(rst), .in_start(in_start), .in_data_valid(in_data_valid),
    .in_data(in_data), .in_bytes_valid(in_bytes_valid), .in_commit(in_commit),
    .in_drop(in_drop), .out_start(o_start[1]), .out_data_valid(o_dv[1]),
    .out_data(o_data[1]), .out_bytes_valid(o_bv[1]), .out_commit(o_commit[1]),
    .tx_busy(tx_busy), .overflow_drop(o_ovf[1]), .grant_port(o_gp[1]));

  int errors = 0;
  int checks = 0;

  // observed stream, index 0 = round-robin instance, 1 = priority instance
  int    cyc = 0;
  word_t got_w   [2][$];
  int    got_len [2][$];
  int    got_port[2][$];
  int    cur_len [2];
  bit    in_frame[2];
  int    proto_err[2];
  int    start_cyc[2];
  int    ovf_cnt [2][NP];

  // reference model
  word_t mq_w  [NP][$];
  int    mq_len[NP][$];
  int    m_occ [NP];
  int    m_rr;
  int    exp_ovf[NP];
  word_t exp_w   [2][$];
  int    exp_len [2][$];
  int    exp_port[2][$];
  word_t fw[$];

  always @(negedge clk) begin
    cyc++;
    for (int d = 0; d < 2; d++) begin
      for (int p = 0; p < NP; p++)
        if (o_ovf[d][p] === 1'b1) ovf_cnt[d][p]++;
      if (rst) begin
        in_frame[d] = 1'b0;
      end else if (o_start[d]) begin
        if (in_frame[d]) proto_err[d]++;
        in_frame[d]  = 1'b1;
        cur_len[d]   = 0;
        start_cyc[d] = cyc;
        got_port[d].push_back(int'(o_gp[d]));
      end else if (o_dv[d]) begin
        if (!in_frame[d]) proto_err[d]++;
        got_w[d].push_back({o_bv[d], o_data[d]});
        cur_len[d]++;
      end else if (o_commit[d]) begin
        if (!in_frame[d] || cur_len[d] == 0 || cyc - start_cyc[d] != cur_len[d] + 1)
          proto_err[d]++;
        got_len[d].push_back(cur_len[d]);
        in_frame[d] = 1'b0;
      end else if (in_frame[d]) begin
        proto_err[d]++;
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_random(input int n);
    fw.delete();
    for (int i = 0; i < n; i++)
      fw.push_back({3'($urandom_range(1, 4)), 32'($urandom)});
  endtask

  task automatic send_frame(input int p, input bit drop);
    in_start[p] = 1'b1;
    tick();
    in_start[p] = 1'b0;
    foreach (fw[i]) begin
      in_data_valid[p]            = 1'b1;
      in_data[p*DW +: DW]         = fw[i][DW-1:0];
      in_bytes_valid[p*BV +: BV]  = fw[i][BV+DW-1:DW];
      tick();
    end
    in_data_valid[p] = 1'b0;
    if (drop) in_drop[p] = 1'b1;
    else      in_commit[p] = 1'b1;
    tick();
    in_drop[p]   = 1'b0;
    in_commit[p] = 1'b0;
    if (!drop && fw.size() > 0) begin
      if (m_occ[p] + fw.size() > DEPTH || mq_len[p].size() == MAXF) begin
        exp_ovf[p]++;
      end else begin
        mq_len[p].push_back(fw.size());
        foreach (fw[i]) mq_w[p].push_back(fw[i]);
        m_occ[p] += fw.size();
      end
    end
  endtask

  // order in which queued frames leave each instance once tx_busy drops
  task automatic model_release();
    for (int d = 0; d < 2; d++) begin
      int cnt[NP];
      int fidx[NP];
      int woff[NP];
      int r, total, q, n;
      r = (d == 0) ? m_rr : 0;
      total = 0;
      for (int p = 0; p < NP; p++) begin
        cnt[p]  = mq_len[p].size();
        fidx[p] = 0;
        woff[p] = 0;
        total  += cnt[p];
      end
      while (total > 0) begin
        q = -1;
        for (int i = 0; i < NP; i++) begin
          int c;
          c = (r + i) % NP;
          if (q < 0 && cnt[c] > 0) q = c;
        end
        n = mq_len[q][fidx[q]];
        exp_port[d].push_back(q);
        exp_len[d].push_back(n);
        for (int k = 0; k < n; k++) exp_w[d].push_back(mq_w[q][woff[q] + k]);
        woff[q] += n;
        fidx[q]++;
        cnt[q]--;
        total--;
        if (d == 0) r = (q + 1) % NP;
      end
      if (d == 0) m_rr = r;
    end
    for (int p = 0; p < NP; p++) begin
      mq_w[p].delete();
      mq_len[p].delete();
      m_occ[p] = 0;
    end
  endtask

  task automatic model_reset();
    for (int p = 0; p < NP; p++) begin
      mq_w[p].delete();
      mq_len[p].delete();
      m_occ[p] = 0;
    end
    m_rr = 0;
    for (int d = 0; d < 2; d++) begin
      exp_w[d].delete();  exp_len[d].delete();  exp_port[d].delete();
      got_w[d].delete();  got_len[d].delete();  got_port[d].delete();
    end
  endtask

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    while ((got_len[0].size() < exp_len[0].size() || got_len[1].size() < exp_len[1].size())
           && n < 3000) begin
      tick();
      n++;
    end
    check({tag, "_drain_timeout"}, 64'(n < 3000), 64'd1);
    repeat (4) tick();
  endtask

  task automatic compare_stream(input string tag);
    for (int d = 0; d < 2; d++) begin
      string t;
      t = $sformatf("%s_d%0d", tag, d);
      check({t, "_nframes"}, 64'(got_len[d].size()), 64'(exp_len[d].size()));
      check({t, "_nstarts"}, 64'(got_port[d].size()), 64'(exp_port[d].size()));
      check({t, "_nwords"},  64'(got_w[d].size()),   64'(exp_w[d].size()));
      for (int i = 0; i < exp_len[d].size() && i < got_len[d].size(); i++)
        check($sformatf("%s_len%0d", t, i), 64'(got_len[d][i]), 64'(exp_len[d][i]));
      for (int i = 0; i < exp_port[d].size() && i < got_port[d].size(); i++)
        check($sformatf("%s_port%0d", t, i), 64'(got_port[d][i]), 64'(exp_port[d][i]));
      for (int i = 0; i < exp_w[d].size() && i < got_w[d].size(); i++)
        check($sformatf("%s_word%0d", t, i), 64'(got_w[d][i]), 64'(exp_w[d][i]));
      check({t, "_protocol"}, 64'(proto_err[d]), 64'd0);
      for (int p = 0; p < NP; p++)
        check($sformatf("%s_ovf%0d", t, p), 64'(ovf_cnt[d][p]), 64'(exp_ovf[p]));
      exp_w[d].delete();  exp_len[d].delete();  exp_port[d].delete();
      got_w[d].delete();  got_len[d].delete();  got_port[d].delete();
    end
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    model_reset();
  endtask

  initial begin
    int n, rel;
    int rr_exp[6];
    int pr_exp[6];
    rr_exp = '{0, 1, 3, 0, 1, 3};
    pr_exp = '{0, 0, 1, 1, 3, 3};
    rst = 1'b1;
    in_start = '0; in_data_valid = '0; in_commit = '0; in_drop = '0;
    in_data = '0; in_bytes_valid = '0; tx_busy = 1'b0;
    for (int p = 0; p < NP; p++) exp_ovf[p] = 0;
    model_reset();
    repeat (3) tick();

    for (int d = 0; d < 2; d++) begin
      check($sformatf("reset_start_d%0d", d),  64'(o_start[d]),  64'd0);
      check($sformatf("reset_dv_d%0d", d),     64'(o_dv[d]),     64'd0);
      check($sformatf("reset_commit_d%0d", d), 64'(o_commit[d]), 64'd0);
      check($sformatf("reset_data_d%0d", d),   64'(o_data[d]),   64'd0);
      check($sformatf("reset_bv_d%0d", d),     64'(o_bv[d]),     64'd0);
      check($sformatf("reset_ovf_d%0d", d),    64'(o_ovf[d]),    64'd0);
      check($sformatf("reset_gp_d%0d", d),     64'(o_gp[d]),     64'd0);
    end
    rst = 1'b0;
    tick();

    // single directed frame on port 2
    fw.delete();
    for (int i = 0; i < 5; i++) fw.push_back({(i == 4) ? 3'd2 : 3'd4, 32'(17 * (i + 1))});
    send_frame(2, 1'b0);
    model_release();
    wait_drain("single");
    check("single_hold_data", 64'(o_data[0]), 64'h55);
    check("single_hold_bv",   64'(o_bv[0]),   64'd2);
    check("single_gp",        64'(o_gp[0]),   64'd2);
    compare_stream("single");

    // two frames each on ports 0, 1, 3 queued before the drain
    reset_dut();
    tx_busy = 1'b1;
    for (int k = 0; k < 2; k++)
      foreach (rr_exp[j]) if (j < 3) begin
        fill_random(3);
        send_frame(rr_exp[j], 1'b0);
      end
    tx_busy = 1'b0;
    model_release();
    wait_drain("arb");
    for (int i = 0; i < 6; i++) begin
      if (i < got_port[0].size()) check($sformatf("rr_order%0d", i), 64'(got_port[0][i]), 64'(rr_exp[i]));
      if (i < got_port[1].size()) check($sformatf("pr_order%0d", i), 64'(got_port[1][i]), 64'(pr_exp[i]));
    end
    compare_stream("arb");

    // overflow then a good frame on port 1
    fill_random(20);
    send_frame(1, 1'b0);
    model_release();
    repeat (10) tick();
    compare_stream("ovf_big");
    fill_random(4);
    send_frame(1, 1'b0);
    model_release();
    wait_drain("ovf_next");
    compare_stream("ovf_next");

    // drop, then a commit held back by tx_busy
    tx_busy = 1'b1;
    fill_random(3);
    send_frame(0, 1'b1);
    fill_random(2);
    send_frame(0, 1'b0);
    repeat (10) tick();
    check("busy_no_start_rr", 64'(got_port[0].size()), 64'd0);
    check("busy_no_start_pr", 64'(got_port[1].size()), 64'd0);
    tx_busy = 1'b0;
    rel = cyc;
    model_release();
    wait_drain("busy");
    check("busy_start_cyc_rr", 64'(start_cyc[0]), 64'(rel + 2));
    check("busy_start_cyc_pr", 64'(start_cyc[1]), 64'(rel + 2));
    compare_stream("busy");

    // reset in the middle of an 8-word frame
    fill_random(8);
    send_frame(3, 1'b0);
    n = 0;
    while (o_dv[0] !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    check("midrst_wait_dv", 64'(n < 50), 64'd1);
    tick();
    tick();
    rst = 1'b1;
    tick();
    for (int d = 0; d < 2; d++) begin
      check($sformatf("midrst_start_d%0d", d),  64'(o_start[d]),  64'd0);
      check($sformatf("midrst_dv_d%0d", d),     64'(o_dv[d]),     64'd0);
      check($sformatf("midrst_commit_d%0d", d), 64'(o_commit[d]), 64'd0);
      check($sformatf("midrst_data_d%0d", d),   64'(o_data[d]),   64'd0);
      check($sformatf("midrst_gp_d%0d", d),     64'(o_gp[d]),     64'd0);
    end
    tick();
    rst = 1'b0;
    repeat (20) tick();
    for (int d = 0; d < 2; d++) begin
      check($sformatf("midrst_nocommit_d%0d", d), 64'(got_len[d].size()),  64'd0);
      check($sformatf("midrst_empty_d%0d", d),    64'(got_port[d].size()), 64'd1);
    end
    model_reset();
    fill_random(3);
    send_frame(0, 1'b0);
    model_release();
    wait_drain("after_rst");
    compare_stream("after_rst");

    // randomized bursts, mixing drops, zero-length and overflowing frames
    for (int r = 0; r < 4; r++) begin
      int nf;
      tx_busy = 1'b1;
      nf = $urandom_range(3, 8);
      for (int f = 0; f < nf; f++) begin
        int p, len;
        bit drop;
        p    = $urandom_range(0, NP - 1);
        len  = $urandom_range(0, 9);
        drop = ($urandom_range(0, 5) == 0);
        fill_random(len);
        send_frame(p, drop);
      end
      tx_busy = 1'b0;
      model_release();
      wait_drain($sformatf("rand%0d", r));
      compare_stream($sformatf("rand%0d", r));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
